// File: rtl/fetch_pkg.sv
// Shared widths and FSM encoding for the instruction fetch sequencer.
// The FAULT state only exists when FETCH_PARITY_EN is defined.
package fetch_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 19;

  typedef enum logic [2:0] {
    ST_REQ,
    ST_VALID,
    ST_ADV,
    ST_DROP
`ifdef FETCH_PARITY_EN
    , ST_FAULT
`endif
  } fetch_state_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction-memory read bus (req/ack). The parity bit imem_rpar is only
// present when FETCH_PARITY_EN is defined.
interface fetch_if;
  import fetch_pkg::*;

  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;

`ifdef FETCH_PARITY_EN
  logic               imem_rpar;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata, imem_rpar);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata, imem_rpar);
`else
  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
`endif

endinterface

// File: rtl/fetch_parity.sv
// Combinational odd-parity checker over {par, data}; only built with
// FETCH_PARITY_EN defined.
`ifdef FETCH_PARITY_EN
module fetch_parity
  import fetch_pkg::*;
(
  input  logic [INSTR_W-1:0] data,
  input  logic               par,
  output logic               err
);

  // Odd parity: the total number of ones must be odd.
  assign err = ~(^{par, data});

endmodule
`endif

// File: rtl/fetch_unit.sv
// Fetch sequencer: pc -> imem req/ack -> decoder valid/ready -> next_pc/pcwrite.
// FETCH_PARITY_EN adds imem_rpar checking and a sticky fetch_fault.
module fetch_unit
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_W-1:0]    pc,
  output logic               pcwrite,
  output logic [PC_W-1:0]    next_pc,
  fetch_if.master            imem,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  input  logic               dec_ready,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               fetch_fault
);

  fetch_state_t       state_q, state_d;
  logic               req_q, req_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [PC_W-1:0]    instr_pc_q, instr_pc_d;
  logic [PC_W-1:0]    target_q, target_d;
  logic [PC_W-1:0]    next_pc_q, next_pc_d;
  logic               pcwrite_q, pcwrite_d;
  logic               valid_q, valid_d;
  logic               fault_q, fault_d;

  logic               xfer;
  logic               enter_adv;
  logic [PC_W-1:0]    adv_pc;

  assign xfer = req_q & imem.imem_ack;

`ifdef FETCH_PARITY_EN
  logic par_err;

  fetch_parity u_parity (
    .data (imem.imem_rdata),
    .par  (imem.imem_rpar),
    .err  (par_err)
  );
`endif

  always_comb begin
    // NOTE: every _d and helper gets a default first, so no path leaves one unassigned and no latch is inferred.
    state_d    = state_q;
    req_d      = req_q;
    addr_d     = addr_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    target_d   = target_q;
    next_pc_d  = next_pc_q;
    pcwrite_d  = 1'b0;
    valid_d    = valid_q;
    fault_d    = fault_q;
    enter_adv  = 1'b0;
    adv_pc     = target_q;

    case (state_q)
      ST_REQ: begin
        req_d = 1'b1;
        // First cycle after reset has no request out yet; launch it from pc.
        if (!req_q) addr_d = pc;
        if (xfer && !redirect) begin
          instr_d    = imem.imem_rdata;
          instr_pc_d = addr_q;
          req_d      = 1'b0;
          valid_d    = 1'b1;
          state_d    = ST_VALID;
        end else if (xfer) begin
          enter_adv = 1'b1;
          adv_pc    = redirect_pc;
        end else if (redirect) begin
          target_d = redirect_pc;
          state_d  = ST_DROP;
        end
      end
      ST_VALID: begin
        if (redirect) begin
          enter_adv = 1'b1;
          adv_pc    = redirect_pc;
        end else if (dec_ready) begin
          enter_adv = 1'b1;
          adv_pc    = instr_pc_q + 1'b1;
        end
      end
      ST_ADV: begin
        if (redirect) begin
          enter_adv = 1'b1;
          adv_pc    = redirect_pc;
        end else begin
          // pc loads next_pc on this edge, so target is the new pc value.
          req_d   = 1'b1;
          addr_d  = target_q;
          state_d = ST_REQ;
        end
      end
      ST_DROP: begin
        if (xfer) begin
          enter_adv = 1'b1;
          adv_pc    = redirect ? redirect_pc : target_q;
        end else if (redirect) begin
          target_d = redirect_pc;
        end
      end
`ifdef FETCH_PARITY_EN
      ST_FAULT: begin
        req_d   = 1'b0;
        valid_d = 1'b0;
      end
`endif
      default: state_d = ST_REQ;
    endcase

    if (enter_adv) begin
      state_d   = ST_ADV;
      target_d  = adv_pc;
      next_pc_d = adv_pc;
      pcwrite_d = 1'b1;
      req_d     = 1'b0;
      valid_d   = 1'b0;
    end

`ifdef FETCH_PARITY_EN
    // Parity is checked on every transfer, including ones being discarded.
    if (xfer && par_err) begin
      state_d   = ST_FAULT;
      fault_d   = 1'b1;
      req_d     = 1'b0;
      valid_d   = 1'b0;
      pcwrite_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_REQ;
      req_q      <= 1'b0;
      addr_q     <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
      target_q   <= '0;
      next_pc_q  <= '0;
      pcwrite_q  <= 1'b0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      target_q   <= target_d;
      next_pc_q  <= next_pc_d;
      pcwrite_q  <= pcwrite_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign instr_valid    = valid_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign pcwrite        = pcwrite_q;
  assign next_pc        = next_pc_q;
  assign fetch_fault    = fault_q;

endmodule
